// File: rtl/ad7606_pkg.sv
`default_nettype none
//==============================================================================
// Module   : ad7606_pkg
// Brief    : Shared types and constants for the AD7606 acquisition sequencer.
// Revision : 1.0 - initial release
//==============================================================================
package ad7606_pkg;

    localparam int P_NCH      = 8;
    localparam int CH_W       = 16;
    localparam int MIN_PERIOD = 230;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } acq_state_t;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int n = 7; n >= 0; n--) begin
            if (v[n]) lowest_set = 3'(n);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad7606_frame_serializer.sv
`default_nettype none
//==============================================================================
// Module   : ad7606_frame_serializer
// Brief    : Two-entry ping-pong frame buffer walking enabled channels onto a
//            ready/valid stream.
// Revision : 1.0 - initial release
//==============================================================================
module ad7606_frame_serializer
    import ad7606_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [P_NCH-1:0]        mask,
    input  logic                    wr_en,
    input  logic [P_NCH*CH_W-1:0]   wr_data,
    output logic                    wr_ok,
    output logic                    idle,
    output logic [CH_W-1:0]         m_data,
    output logic [2:0]              m_chnl,
    output logic                    m_last,
    output logic                    m_valid,
    input  logic                    m_ready
);

    logic [P_NCH*CH_W-1:0] frame_buf [2];
    logic [1:0]            full;
    logic [1:0]            full_next;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [P_NCH-1:0]      sent;
    logic [P_NCH-1:0]      remaining;
    logic [P_NCH-1:0]      cur_bit;
    logic [2:0]            cur;
    logic                  beat_last;
    logic                  beat;
    logic                  free_now;

    // Channels still owed from the frame at the read pointer.
    assign remaining = mask & ~sent;
    assign cur       = lowest_set(remaining);
    assign cur_bit   = P_NCH'(1) << cur;
    assign beat_last = (remaining & ~cur_bit) == '0;

    assign m_valid  = full[rd_ptr];
    assign beat     = m_valid && m_ready;
    assign free_now = beat && beat_last;

    // The slot being freed this cycle may be refilled in the same cycle.
    assign wr_ok = wr_en && (!full[wr_ptr] || (free_now && (rd_ptr == wr_ptr)));
    assign idle  = (full == 2'b00);

    assign m_data = m_valid ? frame_buf[rd_ptr][cur*CH_W +: CH_W] : '0;
    assign m_chnl = m_valid ? cur : 3'd0;
    assign m_last = m_valid && beat_last;

    always_comb begin
        full_next = full;
        if (free_now) full_next[rd_ptr] = 1'b0;
        if (wr_ok)    full_next[wr_ptr] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full   <= 2'b00;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            sent   <= '0;
        end else begin
            full <= full_next;
            if (wr_ok)    wr_ptr <= ~wr_ptr;
            if (free_now) rd_ptr <= ~rd_ptr;
            if (beat)     sent   <= free_now ? '0 : (sent | cur_bit);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) frame_buf[wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/ad7606_acq_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : ad7606_acq_ctrl
// Brief    : Acquisition sequencer: drives the AD7606 driver, assembles sample
//            frames and streams enabled channels toward the packetiser.
// Revision : 1.0 - initial release
//==============================================================================
module ad7606_acq_ctrl #(
    parameter int P_CNT_W = 32,
    parameter int P_NCH   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [23:0]        i_cfg_period,
    input  logic [P_CNT_W-1:0] i_cfg_samples,
    input  logic               i_cfg_trig_mode,
    input  logic [7:0]         i_cfg_chnl_mask,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_ext_trig,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow,
    output logic [P_CNT_W-1:0] o_frame_cnt,
    output logic               o_drv_user_ctrl,
    output logic               o_drv_trig_mode,
    output logic [23:0]        o_drv_cap_speed,
    input  logic [7:0]         i_drv_valid,
    input  logic [127:0]       i_drv_data,
    output logic [15:0]        o_m_data,
    output logic [2:0]         o_m_chnl,
    output logic               o_m_last,
    output logic               o_m_valid,
    input  logic               i_m_ready
);
    import ad7606_pkg::*;

    acq_state_t          state;
    logic [23:0]         cfg_period;
    logic [P_CNT_W-1:0]  cfg_samples;
    logic                cfg_trig;
    logic [7:0]          cfg_mask;
    logic                stop_pend;

    logic [7:0]          have;
    logic [7:0]          have_next;
    logic [CH_W-1:0]     slot [P_NCH];
    logic [P_NCH*CH_W-1:0] frame_flat;
    logic                frame_done;
    logic                frame_accept;
    logic                commit_pend;
    logic                wr_ok;
    logic                ser_idle;
    logic                count_open;
    logic                count_hit;

    assign count_open   = (cfg_samples == '0) || (o_frame_cnt < cfg_samples);
    assign count_hit    = (cfg_samples != '0) && (o_frame_cnt == cfg_samples);

    // Channel 0 opens a new frame; channel 7 closes it if every slot was filled.
    assign have_next    = (i_drv_valid[0] ? 8'h00 : have) | i_drv_valid;
    assign frame_done   = i_drv_valid[P_NCH-1] && (&have_next);
    assign frame_accept = frame_done && (state == ST_RUN) && count_open;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_drv_user_ctrl <= 1'b0;
            o_drv_trig_mode <= 1'b0;
            o_drv_cap_speed <= '0;
            cfg_period      <= '0;
            cfg_samples     <= '0;
            cfg_trig        <= 1'b0;
            cfg_mask        <= '0;
            stop_pend       <= 1'b0;
        end else begin
            o_done          <= 1'b0;
            o_drv_trig_mode <= (state == ST_ARM) ? i_cfg_trig_mode : cfg_trig;
            o_drv_cap_speed <= (state == ST_ARM) ? i_cfg_period    : cfg_period;
            case (state)
                ST_IDLE: begin
                    o_drv_user_ctrl <= 1'b0;
                    if (i_start) begin
                        state  <= ST_ARM;
                        o_busy <= 1'b1;
                    end
                end
                ST_ARM: begin
                    cfg_period      <= i_cfg_period;
                    cfg_samples     <= i_cfg_samples;
                    cfg_trig        <= i_cfg_trig_mode;
                    cfg_mask        <= (i_cfg_chnl_mask == 8'h00) ? 8'hFF : i_cfg_chnl_mask;
                    stop_pend       <= i_stop;
                    o_drv_user_ctrl <= i_cfg_trig_mode ? i_ext_trig : 1'b1;
                    state           <= ST_RUN;
                end
                ST_RUN: begin
                    if (i_stop || stop_pend || count_hit) begin
                        state           <= ST_DRAIN;
                        stop_pend       <= 1'b0;
                        o_drv_user_ctrl <= 1'b0;
                    end else begin
                        o_drv_user_ctrl <= cfg_trig ? i_ext_trig : 1'b1;
                    end
                end
                ST_DRAIN: begin
                    o_drv_user_ctrl <= 1'b0;
                    if (!commit_pend && ser_idle) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Assembly bookkeeping and the commit that follows a completed frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            have        <= '0;
            commit_pend <= 1'b0;
            o_frame_cnt <= '0;
            o_overflow  <= 1'b0;
        end else begin
            commit_pend <= frame_accept;
            if (state == ST_ARM) begin
                have        <= '0;
                o_frame_cnt <= '0;
                o_overflow  <= 1'b0;
            end else begin
                have <= frame_done ? 8'h00 : have_next;
                if (commit_pend) begin
                    if (wr_ok) begin
                        if (o_frame_cnt != '1) o_frame_cnt <= o_frame_cnt + P_CNT_W'(1);
                    end else begin
                        o_overflow <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int n = 0; n < P_NCH; n++) begin
            if (i_drv_valid[n]) slot[n] <= i_drv_data[n*CH_W +: CH_W];
        end
    end

    always_comb begin
        frame_flat = '0;
        for (int n = 0; n < P_NCH; n++) frame_flat[n*CH_W +: CH_W] = slot[n];
    end

    // Host must not program a period shorter than the converter cycle.
    a_min_period: assert property (@(posedge i_clk) disable iff (i_rst)
        (state == ST_ARM) |-> (i_cfg_period >= 24'(MIN_PERIOD)));

    ad7606_frame_serializer u_serializer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .mask    (cfg_mask),
        .wr_en   (commit_pend),
        .wr_data (frame_flat),
        .wr_ok   (wr_ok),
        .idle    (ser_idle),
        .m_data  (o_m_data),
        .m_chnl  (o_m_chnl),
        .m_last  (o_m_last),
        .m_valid (o_m_valid),
        .m_ready (i_m_ready)
    );

endmodule
`default_nettype wire

// File: doc/ad7606_acq_ctrl.md
Name: ad7606_acq_ctrl

Overview:
Acquisition sequencer in front of the AD7606 driver.
- Takes a host configuration: sample period, sample count, trigger mode and channel mask.
- Drives the driver's user_ctrl, trig_mode and cap_speed inputs.
- Collects the eight per-channel valid/data pulses into complete sample frames in a two-entry ping-pong frame buffer.
- Serialises the enabled channels onto one ready/valid stream, tagged with channel number and a frame-last marker, toward the packetiser/DMA.

Parameters:
P_CNT_W, 32, width of sample-count config and counter
P_NCH, 8, ADC channel count (fixed 8 for AD7606; used for loop bounds)

Ports:
i_clk  in  1  system clock, 50 MHz
i_rst  in  1  reset
i_cfg_period  in  24  sample period in i_clk cycles, passed to driver
i_cfg_samples  in  P_CNT_W  frames to capture; 0 = continuous
i_cfg_trig_mode  in  1  0 = free-run, 1 = external trigger
i_cfg_chnl_mask  in  8  bit n enables channel n; 0 treated as 8'hFF
i_start  in  1  single-cycle start pulse
i_stop  in  1  single-cycle abort pulse
i_ext_trig  in  1  external trigger, already synchronised
o_busy  out  1  high outside IDLE
o_done  out  1  one-cycle pulse on return to IDLE
o_overflow  out  1  sticky frame-drop flag, cleared on start
o_frame_cnt  out  P_CNT_W  frames accepted this run
o_drv_user_ctrl  out  1  to driver i_user_ctrl
o_drv_trig_mode  out  1  to driver i_trig_mode
o_drv_cap_speed  out  24  to driver i_cap_speed
i_drv_valid  in  8  driver o_user_valid_1..8, bit n = channel n
i_drv_data  in  128  driver o_user_data_1..8, [16n+15:16n] = channel n
o_m_data  out  16  sample
o_m_chnl  out  3  channel index
o_m_last  out  1  highest enabled channel of frame
o_m_valid  out  1  stream valid
i_m_ready  in  1  stream ready

Behaviour:
- Reset (async, i_rst high): state IDLE; all outputs 0; o_drv_cap_speed 0; both frame buffers empty; counters 0.
- Config is latched in ARM only; later changes are ignored until the next start.
- State machine:
  - IDLE: on i_start go to ARM; i_stop is ignored.
  - ARM (1 cycle): latch config, coerce mask 0 to FF, clear o_frame_cnt, o_overflow and the assembly register, then go to RUN.
  - RUN:
    - o_drv_user_ctrl = trig_mode ? i_ext_trig : 1. The driver edge-detects in trigger mode.
    - i_stop or count reached (o_frame_cnt == cfg_samples, cfg_samples != 0) goes to DRAIN.
  - DRAIN:
    - o_drv_user_ctrl = 0.
    - Wait until both buffers are empty and no beat is pending, then go to IDLE with o_done pulsed for 1 cycle.
- o_drv_trig_mode and o_drv_cap_speed are registered from the latched config.
- Frame assembly:
  - Any i_drv_valid bit n writes its data into assembly slot n and sets the slot's have-bit.
  - A bit-0 pulse clears the other have-bits (new frame).
  - Frame completes on the cycle i_drv_valid[7] is seen with all 8 have-bits set.
  - Completed frames are only accepted in RUN and while o_frame_cnt < cfg_samples (or continuous).
  - Frames completing in DRAIN/IDLE are discarded. So is a partial frame in flight at stop.
- Commit (cycle after completion):
  - If a buffer is free, the frame is copied into it and o_frame_cnt increments.
  - Otherwise the frame is dropped, o_overflow is set and the count is unchanged.
- Buffers are read in commit order, with ping-pong write and read pointers.
- Serialiser:
  - Walks enabled channels ascending.
  - First beat is valid 2 cycles after the completing i_drv_valid[7] cycle, when the output is idle.
  - o_m_data, o_m_chnl and o_m_last stay stable while o_m_valid && !i_m_ready.
  - A beat completes on valid&&ready. The next beat is presented the following cycle with no bubble.
  - Buffer is freed on the cycle its last beat completes. A commit into that buffer in the same cycle is allowed.
- Simultaneous events:
  - i_start and i_stop in IDLE: start wins.
  - i_stop in ARM: take effect on entering RUN, i.e. RUN exits to DRAIN on its first cycle.
  - Commit and free in the same cycle: both apply.
- Count wraps are impossible: a run stops at cfg_samples; a continuous run saturates the counter at max.

Decomposition:
- Package ad7606_pkg:
  - state encoding (IDLE/ARM/RUN/DRAIN)
  - P_NCH
  - channel-width constant 16
  - minimum period 230 (for checks)
- One sub-module, ad7606_frame_serializer: 2-entry frame buffer plus mask-driven channel walker with ready/valid output. The top module keeps the FSM, driver control, assembly and counters.

Test Plan:
- Free-run, period 250, samples 3, mask FF, ready=1 -> user_ctrl high in RUN only; 24 beats, chnl 0..7 ×3, last on chnl 7; frame_cnt=3; done pulse; overflow=0.
- Mask 8'b1010_0100, samples 2 -> beats chnl 2,5,7 per frame, last on 7, 6 beats total.
- Mask 0 -> behaves as FF.
- Ready held 0 for 3 frames -> frames 1–2 buffered, frame 3 dropped, overflow=1, frame_cnt=2. Release ready -> 16 beats, data stable while stalled, each beat checked against the driver data for frames 1–2.
- Trigger mode, samples 0 -> no frames without i_ext_trig; 4 rising edges -> 4 frames. i_stop -> DRAIN, user_ctrl 0, done after last beat.
- i_stop mid-read (after channel 3 valid) -> partial frame discarded, no beats for it.
- i_rst asserted mid-beat -> all outputs 0 immediately; a new start runs cleanly with frame_cnt from 0.
